// File: rtl/laser_pool.sv
// Pool of NUM_LASERS player lasers: allocation, spawn, per-frame motion, retirement and fire cooldown.
// Define LASER_POOL_AUTOFIRE_EN to fire on the shoot level instead of its rising edge.
module laser_pool #(
  parameter int NUM_LASERS      = 3,
  parameter int X_W             = 10,
  parameter int Y_W             = 10,
  parameter int LASER_STEP      = 4,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int PLAYER_Y        = 440,
  parameter int SPRITE_W        = 32,
  parameter int PROJ_W          = 4,
  parameter int PROJ_H          = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame,
  input  logic                      shoot,
  input  logic [X_W-1:0]            player_x,
  input  logic [NUM_LASERS-1:0]     hit,
  output logic [NUM_LASERS-1:0]     laser_active,
  output logic [NUM_LASERS*X_W-1:0] laser_x,
  output logic [NUM_LASERS*Y_W-1:0] laser_y,
  output logic                      fire_pulse,
  output logic                      pool_full
);

  localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);
  localparam logic [X_W-1:0]  X_OFF   = X_W'(SPRITE_W / 2 - PROJ_W / 2);
  localparam logic [Y_W-1:0]  SPAWN_Y = Y_W'(PLAYER_Y - PROJ_H);
  localparam logic [Y_W-1:0]  STEP    = Y_W'(LASER_STEP);

  logic [CD_W-1:0]           cooldown, cooldown_next;
  logic                      fire_req, spawn, found;
  logic [NUM_LASERS-1:0]     spawn_sel, active_next;
  logic [NUM_LASERS*X_W-1:0] x_next;
  logic [NUM_LASERS*Y_W-1:0] y_next;
  logic [X_W-1:0]            spawn_x;

`ifdef LASER_POOL_AUTOFIRE_EN
  assign fire_req = shoot;
`else
  logic shoot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shoot_q <= 1'b0;
    else        shoot_q <= shoot;
  end

  assign fire_req = shoot & ~shoot_q;
`endif

  assign spawn   = fire_req && (cooldown == '0) && !(&laser_active);
  assign spawn_x = player_x + X_OFF;

  // One-hot pick of the lowest-index free slot
  always_comb begin
    spawn_sel = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_LASERS; i++) begin
      if (!laser_active[i] && !found) begin
        spawn_sel[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  // Spawn beats hit and motion; hit beats motion; top retirement has no wrap
  always_comb begin
    active_next = laser_active;
    x_next      = laser_x;
    y_next      = laser_y;
    for (int i = 0; i < NUM_LASERS; i++) begin
      if (spawn && spawn_sel[i]) begin
        active_next[i]          = 1'b1;
        x_next[i*X_W +: X_W]    = spawn_x;
        y_next[i*Y_W +: Y_W]    = SPAWN_Y;
      end else if (laser_active[i]) begin
        if (hit[i]) begin
          active_next[i] = 1'b0;
        end else if (frame) begin
          if (laser_y[i*Y_W +: Y_W] < STEP) active_next[i] = 1'b0;
          else y_next[i*Y_W +: Y_W] = laser_y[i*Y_W +: Y_W] - STEP;
        end
      end
    end
  end

  always_comb begin
    cooldown_next = cooldown;
    if (spawn)                         cooldown_next = CD_LOAD;
    else if (frame && cooldown != '0)  cooldown_next = cooldown - CD_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      laser_active <= '0;
      laser_x      <= '0;
      laser_y      <= '0;
      fire_pulse   <= 1'b0;
      pool_full    <= 1'b0;
      cooldown     <= '0;
    end else begin
      laser_active <= active_next;
      laser_x      <= x_next;
      laser_y      <= y_next;
      fire_pulse   <= spawn;
      pool_full    <= &active_next;
      cooldown     <= cooldown_next;
    end
  end

endmodule

// File: tb/tb_laser_pool.sv
// Self-checking bench for laser_pool: default instance plus a zero-cooldown instance.
module tb_laser_pool;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame = 1'b0;
  logic       shoot = 1'b0;
  logic [9:0] player_x = '0;
  logic [2:0] hit = '0;

  logic [2:0]  laser_active, nc_active;
  logic [29:0] laser_x, laser_y, nc_x, nc_y;
  logic        fire_pulse, pool_full, nc_fire, nc_full;

  int checks = 0;
  int passed = 0;

  typedef struct {
    int         slot;
    logic [9:0] x;
    logic [9:0] y;
  } spawn_t;

  spawn_t sb[$];
  spawn_t exp_s;

  laser_pool dut (
    .clk(clk), .rst_n(rst_n), .frame(frame), .shoot(shoot), .player_x(player_x), .hit(hit),
    .laser_active(laser_active), .laser_x(laser_x), .laser_y(laser_y),
    .fire_pulse(fire_pulse), .pool_full(pool_full)
  );

  laser_pool #(.COOLDOWN_FRAMES(0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .frame(frame), .shoot(shoot), .player_x(player_x), .hit(hit),
    .laser_active(nc_active), .laser_x(nc_x), .laser_y(nc_y),
    .fire_pulse(nc_fire), .pool_full(nc_full)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] sx(input int i);
    return laser_x[i*10 +: 10];
  endfunction

  function automatic logic [9:0] sy(input int i);
    return laser_y[i*10 +: 10];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame = 1'b1;
      step();
      frame = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (laser_active !== 3'b000) $display("[TB] FAIL reset_active got %b want 000", laser_active); else passed++;
    checks++; if (laser_x !== 30'd0) $display("[TB] FAIL reset_x got %h want 0", laser_x); else passed++;
    checks++; if (laser_y !== 30'd0) $display("[TB] FAIL reset_y got %h want 0", laser_y); else passed++;
    checks++; if (fire_pulse !== 1'b0) $display("[TB] FAIL reset_fire got %b want 0", fire_pulse); else passed++;
    checks++; if (pool_full !== 1'b0) $display("[TB] FAIL reset_full got %b want 0", pool_full); else passed++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_spawn();
    player_x = 10'd100;
    sb.push_back('{0, 10'd114, 10'd424});
    checks++; if (laser_active !== 3'b000) $display("[TB] FAIL pre_spawn_active got %b want 000", laser_active); else passed++;
    shoot = 1'b1;
    step();
    checks++;
    if (fire_pulse === 1'b1 && sb.size() > 0) begin
      exp_s = sb.pop_front();
      passed++;
      checks++; if (laser_active[exp_s.slot] !== 1'b1) $display("[TB] FAIL spawn_active got %b want slot %0d set", laser_active, exp_s.slot); else passed++;
      checks++; if (sx(exp_s.slot) !== exp_s.x) $display("[TB] FAIL spawn_x got %0d want %0d", sx(exp_s.slot), exp_s.x); else passed++;
      checks++; if (sy(exp_s.slot) !== exp_s.y) $display("[TB] FAIL spawn_y got %0d want %0d", sy(exp_s.slot), exp_s.y); else passed++;
    end else begin
      $display("[TB] FAIL spawn_pulse got %b want 1", fire_pulse);
    end
    checks++; if (laser_active !== 3'b001) $display("[TB] FAIL spawn_others got %b want 001", laser_active); else passed++;
    shoot = 1'b0;
    step();
    checks++; if (fire_pulse !== 1'b0) $display("[TB] FAIL pulse_width got %b want 0", fire_pulse); else passed++;
  endtask

  task automatic test_cooldown();
    frames(3);
    checks++; if (sy(0) !== 10'd412) $display("[TB] FAIL move_3 got %0d want 412", sy(0)); else passed++;
    shoot = 1'b1;
    step();
    shoot = 1'b0;
    checks++; if (fire_pulse !== 1'b0 || laser_active !== 3'b001) $display("[TB] FAIL cd_drop got %b/%b want 0/001", fire_pulse, laser_active); else passed++;
    step();
    frames(5);
    sb.push_back('{1, 10'd114, 10'd424});
    shoot = 1'b1;
    step();
    shoot = 1'b0;
    checks++;
    if (fire_pulse === 1'b1 && sb.size() > 0) begin
      exp_s = sb.pop_front();
      passed++;
      checks++; if (sy(exp_s.slot) !== exp_s.y || sx(exp_s.slot) !== exp_s.x) $display("[TB] FAIL cd_spawn_pos got %0d,%0d want %0d,%0d", sx(exp_s.slot), sy(exp_s.slot), exp_s.x, exp_s.y); else passed++;
    end else begin
      $display("[TB] FAIL cd_spawn_pulse got %b want 1", fire_pulse);
    end
    checks++; if (laser_active !== 3'b011) $display("[TB] FAIL cd_active got %b want 011", laser_active); else passed++;
    checks++; if (sy(0) !== 10'd392) $display("[TB] FAIL cd_slot0_y got %0d want 392", sy(0)); else passed++;
    step();
    frames(1);
    checks++; if (sy(0) !== 10'd388 || sy(1) !== 10'd420) $display("[TB] FAIL both_move got %0d,%0d want 388,420", sy(0), sy(1)); else passed++;
  endtask

  task automatic test_flight();
    frames(97);
    checks++; if (sy(0) !== 10'd0 || laser_active[0] !== 1'b1) $display("[TB] FAIL at_top got y=%0d act=%b want 0,1", sy(0), laser_active[0]); else passed++;
    frames(1);
    checks++; if (laser_active !== 3'b010) $display("[TB] FAIL top_retire got %b want 010", laser_active); else passed++;
    checks++; if (sx(0) !== 10'd114 || sy(0) !== 10'd0) $display("[TB] FAIL hold_xy got %0d,%0d want 114,0", sx(0), sy(0)); else passed++;
    checks++; if (sy(1) !== 10'd28) $display("[TB] FAIL slot1_y got %0d want 28", sy(1)); else passed++;
  endtask

  task automatic test_hit_frame();
    hit = 3'b011;
    frame = 1'b1;
    step();
    hit = 3'b000;
    frame = 1'b0;
    checks++; if (laser_active !== 3'b000 || sy(1) !== 10'd28) $display("[TB] FAIL hit_frame got %b y=%0d want 000 y=28", laser_active, sy(1)); else passed++;
    player_x = 10'd1015;
    sb.push_back('{0, 10'd5, 10'd424});
    shoot = 1'b1;
    frame = 1'b1;
    hit = 3'b001;
    step();
    shoot = 1'b0;
    frame = 1'b0;
    hit = 3'b000;
    checks++;
    if (fire_pulse === 1'b1 && sb.size() > 0) begin
      exp_s = sb.pop_front();
      passed++;
      checks++; if (sx(exp_s.slot) !== exp_s.x || sy(exp_s.slot) !== exp_s.y) $display("[TB] FAIL frame_spawn_pos got %0d,%0d want %0d,%0d", sx(exp_s.slot), sy(exp_s.slot), exp_s.x, exp_s.y); else passed++;
    end else begin
      $display("[TB] FAIL frame_spawn_pulse got %b want 1", fire_pulse);
    end
    checks++; if (laser_active !== 3'b001) $display("[TB] FAIL spawn_over_hit got %b want 001", laser_active); else passed++;
    step();
    hit = 3'b001;
    step();
    hit = 3'b000;
    checks++; if (laser_active !== 3'b000 || sy(0) !== 10'd424) $display("[TB] FAIL hit_idle got %b y=%0d want 000 y=424", laser_active, sy(0)); else passed++;
  endtask

  task automatic test_pool_full();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    player_x = 10'd50;
    repeat (3) begin
      shoot = 1'b1;
      step();
      shoot = 1'b0;
      step();
    end
    checks++; if (nc_active !== 3'b111 || nc_full !== 1'b1) $display("[TB] FAIL full got %b/%b want 111/1", nc_active, nc_full); else passed++;
    shoot = 1'b1;
    step();
    shoot = 1'b0;
    checks++; if (nc_fire !== 1'b0) $display("[TB] FAIL full_drop got %b want 0", nc_fire); else passed++;
    step();
    hit = 3'b010;
    step();
    hit = 3'b000;
    checks++; if (nc_active !== 3'b101 || nc_full !== 1'b0) $display("[TB] FAIL full_hit got %b/%b want 101/0", nc_active, nc_full); else passed++;
    player_x = 10'd300;
    sb.push_back('{1, 10'd314, 10'd424});
    shoot = 1'b1;
    step();
    shoot = 1'b0;
    checks++;
    if (nc_fire === 1'b1 && sb.size() > 0) begin
      exp_s = sb.pop_front();
      passed++;
      checks++; if (nc_x[exp_s.slot*10 +: 10] !== exp_s.x || nc_y[exp_s.slot*10 +: 10] !== exp_s.y) $display("[TB] FAIL refill_pos got %0d,%0d want %0d,%0d", nc_x[exp_s.slot*10 +: 10], nc_y[exp_s.slot*10 +: 10], exp_s.x, exp_s.y); else passed++;
    end else begin
      $display("[TB] FAIL refill_pulse got %b want 1", nc_fire);
    end
    checks++; if (nc_active !== 3'b111 || nc_full !== 1'b1) $display("[TB] FAIL refill got %b/%b want 111/1", nc_active, nc_full); else passed++;
    checks++; if (laser_active !== 3'b001) $display("[TB] FAIL cd_blocks_main got %b want 001", laser_active); else passed++;
    step();
  endtask

  task automatic test_async_reset();
    frames(8);
    shoot = 1'b1;
    step();
    shoot = 1'b0;
    checks++; if (laser_active !== 3'b011 || sy(0) !== 10'd392) $display("[TB] FAIL pre_reset got %b y0=%0d want 011 y0=392", laser_active, sy(0)); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (laser_active !== 3'b000 || laser_x !== 30'd0 || laser_y !== 30'd0) $display("[TB] FAIL async_clear got %b %h %h want 0", laser_active, laser_x, laser_y); else passed++;
    checks++; if (pool_full !== 1'b0 || nc_active !== 3'b000 || nc_full !== 1'b0) $display("[TB] FAIL async_status got %b %b %b want 0", pool_full, nc_active, nc_full); else passed++;
    step();
    rst_n = 1'b1;
    step();
  endtask

`ifdef LASER_POOL_AUTOFIRE_EN
  task automatic test_autofire();
    int spawns;
    spawns = 0;
    shoot = 1'b1;
    for (int f = 0; f < 20; f++) begin
      frame = 1'b1;
      step();
      frame = 1'b0;
      if (fire_pulse === 1'b1) spawns++;
      repeat (3) begin
        step();
        if (fire_pulse === 1'b1) spawns++;
      end
    end
    shoot = 1'b0;
    checks++; if (spawns !== 3) $display("[TB] FAIL autofire_count got %0d want 3", spawns); else passed++;
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_spawn();
    test_cooldown();
    test_flight();
    test_hit_frame();
    test_pool_full();
    test_async_reset();
`ifdef LASER_POOL_AUTOFIRE_EN
    test_autofire();
`endif
    checks++; if (sb.size() != 0) $display("[TB] FAIL scoreboard_leftover got %0d want 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
